// File: rtl/moore_seq_ctrl.sv
// moore_seq_ctrl: round-robin arbiter that shares one Moore sequence FSM among N_REQ requesters, streaming each word LSB-first.
// Build option MOORE_SEQ_CTRL_ONES_EN adds rsp_ones, the popcount of rsp_data.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | waiting for a request; grant + latch word in the same cycle
// ST_CLR   | hold the shared FSM in reset (returns it to S0)
// ST_SHIFT | drive word bits onto fsm_x, one per cycle, LSB first
// ST_DRAIN | let the last Y_LAT outputs of the FSM settle and be captured
// ST_RESP  | present rsp_data/rsp_id until the consumer takes them

module moore_seq_ctrl #(
  parameter int WORD_W = 8,
  parameter int N_REQ  = 2,
  parameter int Y_LAT  = 1,
  localparam int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1,
  localparam int CNT_W = (WORD_W > 2) ? $clog2(WORD_W) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ*WORD_W-1:0]   req_data,
  output logic [N_REQ-1:0]          req_ready,
  output logic                      fsm_x,
  output logic                      fsm_n_reset,
  input  logic                      fsm_y,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [WORD_W-1:0]         rsp_data,
  output logic [ID_W-1:0]           rsp_id
`ifdef MOORE_SEQ_CTRL_ONES_EN
  ,
  output logic [$clog2(WORD_W+1)-1:0] rsp_ones
`endif
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLR   = 3'd1,
    ST_SHIFT = 3'd2,
    ST_DRAIN = 3'd3,
    ST_RESP  = 3'd4
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ID_W-1:0]   r_ptr;
  logic [ID_W-1:0]   r_id;
  logic [ID_W-1:0]   w_gnt_id;
  logic [ID_W-1:0]   w_ptr_nxt;
  logic              w_any;
  logic [N_REQ-1:0]  w_upper;
  logic [WORD_W-1:0] r_word;
  logic [WORD_W-1:0] w_gnt_word;
  logic [WORD_W-1:0] r_rsp_data;
  logic [CNT_W-1:0]  r_cnt;
  logic              w_cnt_tc;
  logic              w_capture;

  // Requests at or above the pointer take priority; otherwise wrap to the lowest valid index.
  always_comb begin
    w_upper = '0;
    for (int i = 0; i < N_REQ; i++) begin
      w_upper[i] = req_valid[i] && (ID_W'(i) >= r_ptr);
    end
  end

  always_comb begin
    w_any    = |req_valid;
    w_gnt_id = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) w_gnt_id = ID_W'(i);
    end
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (w_upper[i]) w_gnt_id = ID_W'(i);
    end
  end

  always_comb begin
    w_gnt_word = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_gnt_id == ID_W'(i)) w_gnt_word = req_data[i*WORD_W +: WORD_W];
    end
  end

  assign w_ptr_nxt = (w_gnt_id == ID_W'(N_REQ - 1)) ? '0 : w_gnt_id + ID_W'(1);
  assign w_cnt_tc  = (r_cnt == '0);

  // r_cnt counts down from WORD_W-1 in SHIFT, so bit k is in flight when r_cnt == WORD_W-1-k.
  assign w_capture = (r_state == ST_DRAIN) ||
                     ((r_state == ST_SHIFT) && (int'(r_cnt) <= WORD_W - 1 - Y_LAT));

  always_comb begin
    w_state_nxt = r_state;
    req_ready   = '0;
    fsm_x       = 1'b0;
    fsm_n_reset = 1'b1;
    rsp_valid   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_any) begin
          w_state_nxt = ST_CLR;
          for (int i = 0; i < N_REQ; i++) begin
            req_ready[i] = (w_gnt_id == ID_W'(i));
          end
        end
      end
      ST_CLR: begin
        fsm_n_reset = 1'b0;
        w_state_nxt = ST_SHIFT;
      end
      ST_SHIFT: begin
        fsm_x = r_word[0];
        if (w_cnt_tc) w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (w_cnt_tc) w_state_nxt = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    // Reset overrides everything combinationally so a same-cycle request is never accepted.
    if (reset) begin
      req_ready   = '0;
      fsm_x       = 1'b0;
      fsm_n_reset = 1'b0;
      rsp_valid   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr      <= '0;
      r_id       <= '0;
      r_word     <= '0;
      r_cnt      <= '0;
      r_rsp_data <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_word <= w_gnt_word;
            r_id   <= w_gnt_id;
            r_ptr  <= w_ptr_nxt;
          end
        end
        ST_CLR: begin
          r_cnt      <= CNT_W'(WORD_W - 1);
          r_rsp_data <= '0;
        end
        ST_SHIFT: begin
          r_word <= r_word >> 1;
          r_cnt  <= w_cnt_tc ? CNT_W'(Y_LAT - 1) : r_cnt - CNT_W'(1);
        end
        ST_DRAIN: begin
          if (!w_cnt_tc) r_cnt <= r_cnt - CNT_W'(1);
        end
        default: ;
      endcase
      // Bits enter at the MSB and move down, so the first capture ends up at bit 0.
      if (w_capture) r_rsp_data <= {fsm_y, r_rsp_data[WORD_W-1:1]};
    end
  end

  assign rsp_data = r_rsp_data;
  assign rsp_id   = r_id;

`ifdef MOORE_SEQ_CTRL_ONES_EN
  logic [$clog2(WORD_W+1)-1:0] r_ones;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ones <= '0;
    end else if (r_state == ST_CLR) begin
      r_ones <= '0;
    end else if (w_capture) begin
      r_ones <= r_ones + {{($clog2(WORD_W+1)-1){1'b0}}, fsm_y};
    end
  end

  assign rsp_ones = r_ones;
`endif

endmodule

// File: tb/tb_moore_seq_ctrl.sv
// Testbench for moore_seq_ctrl: drives directed requests against a behavioural Moore FSM, scoreboards grants and responses.
module tb_moore_seq_ctrl;
  localparam int W = 8;
  localparam int N = 2;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic           fsm_x;
  logic           fsm_n_reset;
  logic           fsm_y;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [W-1:0]   rsp_data;
  logic [0:0]     rsp_id;
`ifdef MOORE_SEQ_CTRL_ONES_EN
  logic [3:0]     rsp_ones;
`endif

  always #5 clk = ~clk;

  moore_seq_ctrl dut (
    .clk(clk),
    .reset(reset),
    .req_valid(req_valid),
    .req_data(req_data),
    .req_ready(req_ready),
    .fsm_x(fsm_x),
    .fsm_n_reset(fsm_n_reset),
    .fsm_y(fsm_y),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_data(rsp_data),
    .rsp_id(rsp_id)
`ifdef MOORE_SEQ_CTRL_ONES_EN
    ,
    .rsp_ones(rsp_ones)
`endif
  );

  // Shared Moore FSM; y=0 only in states B and C. Hand traces (LSB first):
  // 00 -> FF, FF -> 49, B4 -> 6B, 5A -> B5.
  typedef enum logic [2:0] {M_S0, M_Z, M_A, M_B, M_C, M_D} mstate_t;
  mstate_t m_st;

  always @(posedge clk) begin
    if (!fsm_n_reset) m_st <= M_S0;
    else begin
      case (m_st)
        M_S0:    m_st <= fsm_x ? M_A : M_Z;
        M_Z:     m_st <= fsm_x ? M_B : M_Z;
        M_A:     m_st <= fsm_x ? M_B : M_D;
        M_B:     m_st <= fsm_x ? M_C : M_D;
        M_C:     m_st <= fsm_x ? M_A : M_D;
        M_D:     m_st <= fsm_x ? M_C : M_Z;
        default: m_st <= M_S0;
      endcase
    end
  end
  assign fsm_y = !(m_st == M_B || m_st == M_C);

  typedef struct {
    int           id;
    logic [W-1:0] data;
    int           acc;
  } rsp_exp_t;

  rsp_exp_t     sb_q[$];
  int           gnt_q[$];
  logic [W-1:0] exp_rsp [N];
  int           n_chk = 0;
  int           n_pass = 0;
  int           cyc = 0;
  int           gnt_cnt = 0;
  bit           busy = 1'b0;
  bit           prev_valid = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk_eq(input string name, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: grants are checked against the expected order, responses against the scoreboard.
  always @(negedge clk) begin
    int g;
    if (reset) begin
      prev_valid = 1'b0;
    end else begin
      if (busy) begin
        chk_eq("no_ready_while_busy", req_ready, 0);
      end else if (req_ready != '0) begin
        if (gnt_q.size() == 0) begin
          chk_eq("unexpected_grant", req_ready, 0);
        end else begin
          g = gnt_q.pop_front();
          chk_eq("grant_id", req_ready, 1 << g);
          sb_q.push_back('{id: g, data: exp_rsp[g], acc: cyc});
          busy = 1'b1;
          gnt_cnt++;
        end
      end
      if (rsp_valid) begin
        if (sb_q.size() == 0) begin
          chk_eq("unexpected_rsp", rsp_valid, 0);
        end else begin
          if (!prev_valid) chk_eq("rsp_latency", cyc - sb_q[0].acc, 11);
          chk_eq("rsp_data", rsp_data, sb_q[0].data);
          chk_eq("rsp_id", rsp_id, sb_q[0].id);
`ifdef MOORE_SEQ_CTRL_ONES_EN
          chk_eq("rsp_ones", rsp_ones, $countones(sb_q[0].data));
`endif
          if (rsp_ready) begin
            void'(sb_q.pop_front());
            busy = 1'b0;
          end
        end
      end
      prev_valid = rsp_valid;
    end
  end

  task automatic wait_grants(input int tgt);
    for (int i = 0; i < 400 && gnt_cnt < tgt; i++) begin
      @(posedge clk);
      #1;
    end
    chk_eq("grant_wait", gnt_cnt >= tgt, 1);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 400 && (sb_q.size() != 0 || busy || gnt_q.size() != 0); i++) begin
      @(posedge clk);
      #1;
    end
    chk_eq("idle_wait", sb_q.size() + gnt_q.size() + int'(busy), 0);
  endtask

  task automatic send(input int idx, input logic [W-1:0] word, input logic [W-1:0] exp);
    int tgt;
    tgt = gnt_cnt + 1;
    req_data[idx*W +: W] = word;
    exp_rsp[idx] = exp;
    gnt_q.push_back(idx);
    req_valid[idx] = 1'b1;
    wait_grants(tgt);
    req_valid[idx] = 1'b0;
  endtask

  initial begin
    int tgt;
    reset     = 1'b1;
    req_valid = '0;
    req_data  = '0;
    rsp_ready = 1'b1;

    // Reset held three cycles with no requests.
    repeat (3) begin
      @(negedge clk);
      chk_eq("rst_req_ready", req_ready, 0);
      chk_eq("rst_fsm_n_reset", fsm_n_reset, 0);
      chk_eq("rst_rsp_valid", rsp_valid, 0);
      chk_eq("rst_fsm_x", fsm_x, 0);
    end
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk_eq("post_rst_rsp_data", rsp_data, 0);
    chk_eq("post_rst_rsp_id", rsp_id, 0);
    chk_eq("post_rst_fsm_n_reset", fsm_n_reset, 1);

    // Single requests on each port.
    send(0, 8'h00, 8'hFF);
    wait_idle();
    send(1, 8'hFF, 8'h49);
    wait_idle();
    send(1, 8'hB4, 8'h6B);
    wait_idle();

    // Reset with both requests pending: reset wins, then grants alternate from 0.
    @(posedge clk); #1;
    reset      = 1'b1;
    req_data   = {8'hFF, 8'h00};
    exp_rsp[0] = 8'hFF;
    exp_rsp[1] = 8'h49;
    req_valid  = 2'b11;
    repeat (2) begin
      @(negedge clk);
      chk_eq("rst_wins_ready", req_ready, 0);
    end
    gnt_q.push_back(0);
    gnt_q.push_back(1);
    gnt_q.push_back(0);
    gnt_q.push_back(1);
    tgt = gnt_cnt + 4;
    @(posedge clk); #1 reset = 1'b0;
    wait_grants(tgt);
    req_valid = '0;
    wait_idle();

    // Consumer stalls for five cycles while requester 1 waits.
    rsp_ready = 1'b0;
    send(0, 8'h5A, 8'hB5);
    tgt = gnt_cnt + 1;
    req_data[W +: W] = 8'hFF;
    exp_rsp[1] = 8'h49;
    gnt_q.push_back(1);
    req_valid[1] = 1'b1;
    for (int i = 0; i < 40 && !rsp_valid; i++) begin
      @(posedge clk);
      #1;
    end
    chk_eq("stall_rsp_seen", rsp_valid, 1);
    repeat (5) begin
      @(negedge clk);
      chk_eq("stall_rsp_valid", rsp_valid, 1);
      chk_eq("stall_req_ready", req_ready, 0);
    end
    @(posedge clk); #1 rsp_ready = 1'b1;
    wait_grants(tgt);
    req_valid = '0;
    wait_idle();

    // Reset during SHIFT bit 4 discards the word; pointer restarts at 0.
    send(0, 8'hB4, 8'h6B);
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b1;
    sb_q.delete();
    busy = 1'b0;
    @(negedge clk);
    chk_eq("abort_fsm_n_reset", fsm_n_reset, 0);
    chk_eq("abort_fsm_x", fsm_x, 0);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk_eq("abort_rsp_valid", rsp_valid, 0);
    chk_eq("abort_rsp_data", rsp_data, 0);
    chk_eq("abort_req_ready", req_ready, 0);
    @(posedge clk); #1;
    req_data   = {8'hFF, 8'hB4};
    exp_rsp[0] = 8'h6B;
    exp_rsp[1] = 8'h49;
    gnt_q.push_back(0);
    gnt_q.push_back(1);
    tgt = gnt_cnt + 2;
    req_valid = 2'b11;
    wait_grants(tgt);
    req_valid = '0;
    wait_idle();

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
